// File: rtl/z80_bus_cycle_ctrl.sv
// Z80 machine-cycle sequencer: walks T-states for fetch/mem/io cycles, drives the
// active-low bus strobes from registered state and owns the refresh register R.
module z80_bus_cycle_ctrl #(
    parameter int IO_AUTO_WAIT = 1,
    parameter bit RFSH_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       cyc_start,
    input  logic [2:0] cyc_type,
    input  logic       WAIT_L,
    input  logic       r_ld,
    input  logic [7:0] r_din,
    output logic       busy,
    output logic       cyc_done,
    output logic       data_latch,
    output logic       data_oe,
    output logic       rfsh_sel,
    output logic [7:0] r_out,
    output logic       M1_L,
    output logic       MREQ_L,
    output logic       IORQ_L,
    output logic       RD_L,
    output logic       WR_L,
    output logic       RFSH_L,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TA   = 3'd3,
        TW   = 3'd4,
        T3   = 3'd5,
        T4   = 3'd6
    } state_t;

    localparam logic [1:0] TA_LAST = (IO_AUTO_WAIT > 0) ? 2'(IO_AUTO_WAIT - 1) : 2'd0;

    state_t     state, state_n;
    logic [2:0] typ_q;
    logic [1:0] ta_cnt;
    logic [7:0] r_q;

    logic is_fetch, is_memrd, is_memwr, is_io, is_iord, is_iowr;
    logic final_st, accept, in_addr_ph, in_io_ph;

    assign is_fetch = (typ_q == 3'd0);
    assign is_memrd = (typ_q == 3'd1);
    assign is_memwr = (typ_q == 3'd2);
    assign is_iord  = (typ_q == 3'd3);
    assign is_iowr  = (typ_q == 3'd4);
    assign is_io    = is_iord | is_iowr;

    // T3 is the last state for everything except a fetch with refresh enabled.
    assign final_st = (state == T4) || ((state == T3) && !(is_fetch && RFSH_EN));
    assign accept   = cyc_start && (cyc_type <= 3'd4) && ((state == IDLE) || final_st);

    assign in_addr_ph = (state == T1) || (state == T2) || (state == TW);
    assign in_io_ph   = (state == T2) || (state == TA) || (state == TW) || (state == T3);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state  <= IDLE;
            typ_q  <= 3'd0;
            ta_cnt <= 2'd0;
            r_q    <= 8'h00;
        end else begin
            state  <= state_n;
            if (accept) typ_q <= cyc_type;
            ta_cnt <= (state == TA) ? ta_cnt + 2'd1 : 2'd0;
            if (r_ld)
                r_q <= r_din;
            else if (final_st && is_fetch)
                r_q[6:0] <= r_q[6:0] + 7'd1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = T1;
            T1:   state_n = T2;
            T2: begin
                if (is_io && (IO_AUTO_WAIT > 0)) state_n = TA;
                else                             state_n = WAIT_L ? T3 : TW;
            end
            TA:   if (ta_cnt == TA_LAST) state_n = WAIT_L ? T3 : TW;
            TW:   state_n = WAIT_L ? T3 : TW;
            T3: begin
                if (!final_st)   state_n = T4;
                else if (accept) state_n = T1;
                else             state_n = IDLE;
            end
            T4:   state_n = accept ? T1 : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        M1_L       = 1'b1;
        MREQ_L     = 1'b1;
        IORQ_L     = 1'b1;
        RD_L       = 1'b1;
        WR_L       = 1'b1;
        RFSH_L     = 1'b1;
        data_latch = 1'b0;
        data_oe    = 1'b0;
        rfsh_sel   = 1'b0;
        busy       = (state != IDLE);
        cyc_done   = final_st;
        if (is_fetch) begin
            if (in_addr_ph) begin
                M1_L   = 1'b0;
                MREQ_L = 1'b0;
                RD_L   = 1'b0;
                // read data is taken on the edge that leaves T2/TW for T3
                data_latch = ((state == T2) || (state == TW)) && WAIT_L;
            end
            if (RFSH_EN && ((state == T3) || (state == T4))) begin
                RFSH_L   = 1'b0;
                rfsh_sel = 1'b1;
                MREQ_L   = (state == T4);
            end
        end else if (is_memrd || is_memwr) begin
            if (in_addr_ph || (state == T3)) begin
                MREQ_L  = 1'b0;
                RD_L    = !is_memrd;
                WR_L    = !(is_memwr && (state != T1));
                data_oe = is_memwr;
            end
            data_latch = is_memrd && (state == T3);
        end else if (is_io) begin
            if (in_io_ph) begin
                IORQ_L = 1'b0;
                RD_L   = !is_iord;
                WR_L   = !is_iowr;
            end
            data_oe    = is_iowr && (in_io_ph || (state == T1));
            data_latch = is_iord && (state == T3);
        end
    end

    assign r_out     = r_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_z80_bus_cycle_ctrl.sv
// Directed bench for z80_bus_cycle_ctrl: per-scenario tasks with inline checks
// against hand-computed strobe counts and T-state positions.
module tb_z80_bus_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_L = 1'b0;
    logic       cyc_start = 1'b0;
    logic [2:0] cyc_type = 3'd0;
    logic       WAIT_L = 1'b1;
    logic       r_ld = 1'b0;
    logic [7:0] r_din = 8'h00;
    logic       busy, cyc_done, data_latch, data_oe, rfsh_sel;
    logic [7:0] r_out;
    logic       M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // per-cycle statistics gathered by collect
    int n_busy, n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, n_oe, n_rsel;
    int n_latch, latch_idx, n_done, done_idx, wr_first, first_busy;

    z80_bus_cycle_ctrl #(.IO_AUTO_WAIT(1), .RFSH_EN(1'b1)) dut (
        .clk(clk), .rst_L(rst_L), .cyc_start(cyc_start), .cyc_type(cyc_type),
        .WAIT_L(WAIT_L), .r_ld(r_ld), .r_din(r_din), .busy(busy),
        .cyc_done(cyc_done), .data_latch(data_latch), .data_oe(data_oe),
        .rfsh_sel(rfsh_sel), .r_out(r_out), .M1_L(M1_L), .MREQ_L(MREQ_L),
        .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic launch(input logic [2:0] t);
        @(negedge clk);
        cyc_type  = t;
        cyc_start = 1'b1;
        WAIT_L    = 1'b1;
    endtask

    // Runs one cycle already accepted at the last edge; WAIT_L is held low for
    // clock indices wstart..wstart+nw-1 (index 0 = T1).
    task automatic collect(input int wstart, input int nw, input bit chain,
                           input logic [2:0] next_type, input bit ld_at_done);
        n_busy = 0; n_m1 = 0; n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0;
        n_rfsh = 0; n_oe = 0; n_rsel = 0; n_latch = 0; latch_idx = -1;
        n_done = 0; done_idx = -1; wr_first = -1; first_busy = 0;
        for (int idx = 0; idx < 40; idx++) begin
            @(negedge clk);
            if (idx == 0) cyc_start = 1'b0;
            WAIT_L = !((idx >= wstart) && (idx < wstart + nw));
            #1;
            if (idx == 0) first_busy = int'(busy);
            n_busy += int'(busy);   n_m1   += int'(!M1_L);
            n_mreq += int'(!MREQ_L); n_iorq += int'(!IORQ_L);
            n_rd   += int'(!RD_L);  n_wr   += int'(!WR_L);
            n_rfsh += int'(!RFSH_L); n_oe  += int'(data_oe);
            n_rsel += int'(rfsh_sel);
            if (!WR_L && wr_first < 0) wr_first = idx;
            if (data_latch) begin n_latch++; latch_idx = idx; end
            if (cyc_done) begin
                n_done++;
                done_idx = idx;
                if (chain) begin cyc_start = 1'b1; cyc_type = next_type; end
                if (ld_at_done) begin r_ld = 1'b1; r_din = 8'hFF; end
                break;
            end
            if (!busy) break;
        end
        WAIT_L = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}), 63);
        chk("rst_flags", int'({cyc_done, data_latch, data_oe, rfsh_sel}), 0);
        chk("rst_r", int'(r_out), 0);
        @(negedge clk);
        rst_L = 1'b1;
    endtask

    task automatic test_fetch();
        launch(3'd0);
        collect(0, 0, 1'b0, 3'd0, 1'b0);
        chk("fetch_m1", n_m1, 2);
        chk("fetch_mreq", n_mreq, 3);
        chk("fetch_rd", n_rd, 2);
        chk("fetch_latch_idx", latch_idx, 1);
        chk("fetch_latch_cnt", n_latch, 1);
        chk("fetch_rfsh", n_rfsh, 2);
        chk("fetch_rfsh_sel", n_rsel, 2);
        chk("fetch_done_idx", done_idx, 3);
        @(negedge clk); #1;
        chk("fetch_r_inc", int'(r_out), 8'h01);
        chk("fetch_idle", int'(busy), 0);
    endtask

    task automatic test_mem_read_wait();
        launch(3'd1);
        collect(1, 3, 1'b0, 3'd0, 1'b0);
        chk("mrd_rd", n_rd, 6);
        chk("mrd_mreq", n_mreq, 6);
        chk("mrd_busy", n_busy, 6);
        chk("mrd_latch_cnt", n_latch, 1);
        chk("mrd_latch_idx", latch_idx, 5);
        chk("mrd_done_idx", done_idx, 5);
        chk("mrd_m1", n_m1, 0);
        @(negedge clk); #1;
        chk("mrd_r_hold", int'(r_out), 8'h01);
    endtask

    task automatic test_back_to_back();
        launch(3'd2);
        collect(0, 0, 1'b1, 3'd3, 1'b0);
        chk("mwr_wr", n_wr, 2);
        chk("mwr_wr_first", wr_first, 1);
        chk("mwr_mreq", n_mreq, 3);
        chk("mwr_oe", n_oe, 3);
        chk("mwr_done_idx", done_idx, 2);
        chk("mwr_iorq", n_iorq, 0);
        collect(0, 0, 1'b0, 3'd0, 1'b0);
        chk("b2b_no_gap", first_busy, 1);
        chk("iord_iorq", n_iorq, 3);
        chk("iord_rd", n_rd, 3);
        chk("iord_mreq", n_mreq, 0);
        chk("iord_latch_idx", latch_idx, 3);
        chk("iord_done_idx", done_idx, 3);
        chk("iord_oe", n_oe, 0);
    endtask

    task automatic test_r_load();
        launch(3'd0);
        collect(0, 0, 1'b0, 3'd0, 1'b1);
        chk("rld_done_idx", done_idx, 3);
        @(negedge clk);
        r_ld = 1'b0;
        #1;
        chk("rld_priority", int'(r_out), 8'hFF);
        launch(3'd0);
        collect(0, 0, 1'b0, 3'd0, 1'b0);
        @(negedge clk); #1;
        chk("rld_wrap", int'(r_out), 8'h80);
    endtask

    task automatic test_reset_mid_cycle();
        launch(3'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cyc_start = 1'b0;
            WAIT_L    = 1'b0;
        end
        #1;
        chk("iowr_in_tw", int'(state_dbg), 4);
        chk("iowr_tw_strobes", int'({IORQ_L, WR_L}), 0);
        chk("iowr_tw_oe", int'(data_oe), 1);
        rst_L = 1'b0;
        #1;
        chk("arst_strobes", int'({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}), 63);
        chk("arst_flags", int'({busy, cyc_done, data_oe}), 0);
        @(negedge clk); #1;
        chk("arst_no_done", int'(cyc_done), 0);
        chk("arst_r", int'(r_out), 0);
        rst_L  = 1'b1;
        WAIT_L = 1'b1;
        launch(3'd0);
        collect(0, 0, 1'b0, 3'd0, 1'b0);
        chk("post_rst_m1", n_m1, 2);
        chk("post_rst_done_idx", done_idx, 3);
        @(negedge clk); #1;
        chk("post_rst_r", int'(r_out), 8'h01);
    endtask

    task automatic test_reserved();
        int busy_seen = 0, strobe_low = 0, done_seen = 0;
        @(negedge clk);
        cyc_type  = 3'd6;
        cyc_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            busy_seen  += int'(busy);
            done_seen  += int'(cyc_done);
            strobe_low += int'(!(M1_L & MREQ_L & IORQ_L & RD_L & WR_L & RFSH_L));
        end
        cyc_start = 1'b0;
        chk("rsv_busy", busy_seen, 0);
        chk("rsv_strobes", strobe_low, 0);
        chk("rsv_done", done_seen, 0);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_mem_read_wait();
        test_back_to_back();
        test_r_load();
        test_reset_mid_cycle();
        test_reserved();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
